// File: rtl/mem_responder.sv
// Multi-cycle memory responder. It serves one instruction-fetch or data
// load/store request at a time, and data requests take priority. Each
// accepted request spends LATENCY cycles in BUSY. It then raises a one-cycle
// valid pulse on the port that issued it.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic                    r_src_d;
  logic                    r_wr;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [15:0]             r_wdata;
  logic [15:0]             r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                    w_idle;
  logic                    w_accept_d;
  logic                    w_accept_i;
  logic                    w_access;
  logic                    w_unused;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept_d = w_idle & d_req;
  assign w_accept_i = w_idle & ~d_req & i_req;
  // The access happens on the last BUSY edge. That is the edge where the
  // counter has run down to zero.
  assign w_access   = (r_state == ST_BUSY) && (r_cnt == 4'd0);

  assign d_ready = w_idle;
  assign i_ready = w_idle & ~d_req;
  assign busy    = ~w_idle;
  assign d_valid = (r_state == ST_RESP) &  r_src_d;
  assign i_valid = (r_state == ST_RESP) & ~r_src_d;

  // Byte-address LSB and the bits above the storage depth alias away.
  assign w_unused = ^{i_addr[0], d_addr[0],
                      i_addr[15:DEPTH_LOG2+1], d_addr[15:DEPTH_LOG2+1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next_state unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept_d || w_accept_i) w_next_state = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0)            w_next_state = ST_RESP;
      ST_RESP:                               w_next_state = ST_IDLE;
      default:                               w_next_state = ST_IDLE;
    endcase
  end

  // Latency counter and the request fields captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_src_d <= 1'b0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 16'h0000;
    end else if (w_accept_d) begin
      r_cnt   <= 4'(LATENCY - 1);
      r_src_d <= 1'b1;
      r_wr    <= d_wr;
      r_idx   <= d_addr[DEPTH_LOG2:1];
      r_wdata <= d_wdata;
    end else if (w_accept_i) begin
      r_cnt   <= 4'(LATENCY - 1);
      r_src_d <= 1'b0;
      r_wr    <= 1'b0;
      r_idx   <= i_addr[DEPTH_LOG2:1];
    end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Storage array. A store commits only on its final BUSY edge.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto plain RAM; its contents
    // stay undefined until written.
    if (w_access && r_src_d && r_wr) r_mem[r_idx] <= r_wdata;
  end

  // Read-data registers. Each one holds its value until its own port's next
  // response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= 16'h0000;
      d_rdata <= 16'h0000;
    end else if (w_access) begin
      if (r_src_d) d_rdata <= r_wr ? r_wdata : r_mem[r_idx];
      else         i_rdata <= r_mem[r_idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. It applies directed transactions. A
// cycle-accurate transaction model checks every output on every cycle, and a
// set of literal expectations pins down the model.
module tb_mem_responder;

  localparam int DL2 = 10;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ready, i_valid, d_ready, d_valid, busy;
  logic [15:0] i_rdata, d_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // The cycle number advances on each rising edge and is stable at the
  // falling edge, where all sampling happens.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transaction model. A request seen in an idle cycle c responds in cycle
  // c+LAT+1. The DUT is busy in cycles c+1..c+LAT+1.
  logic        m_pend = 1'b0;
  int          m_resp = 0;
  logic        m_src_d, m_wr;
  int          m_idx;
  logic [15:0] m_wd;
  logic [15:0] m_mem [int];
  logic [15:0] m_irdata = 16'h0, m_drdata = 16'h0;
  logic        m_iknown = 1'b1, m_dknown = 1'b1;

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) % (2 ** (DL2 + 1))) / 2;
  endfunction

  always @(negedge clk) begin
    logic exp_busy, resp_now;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_irdata = 16'h0; m_drdata = 16'h0;
      m_iknown = 1'b1;  m_dknown = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_i_valid", i_valid, 1'b0);
      check("rst_d_valid", d_valid, 1'b0);
      check("rst_i_rdata", i_rdata, 16'h0000);
      check("rst_d_rdata", d_rdata, 16'h0000);
    end else begin
      exp_busy = m_pend && (cyc <= m_resp);
      resp_now = m_pend && (cyc == m_resp);
      if (resp_now) begin
        if (m_src_d && m_wr) begin
          m_mem[m_idx] = m_wd;
          m_drdata = m_wd; m_dknown = 1'b1;
        end else if (m_src_d) begin
          m_dknown = m_mem.exists(m_idx);
          if (m_dknown) m_drdata = m_mem[m_idx];
        end else begin
          m_iknown = m_mem.exists(m_idx);
          if (m_iknown) m_irdata = m_mem[m_idx];
        end
      end
      check("busy", busy, exp_busy);
      check("d_ready", d_ready, !exp_busy);
      check("i_ready", i_ready, !exp_busy && !d_req);
      check("d_valid", d_valid, resp_now && m_src_d);
      check("i_valid", i_valid, resp_now && !m_src_d);
      if (m_dknown) check("d_rdata", d_rdata, m_drdata);
      if (m_iknown) check("i_rdata", i_rdata, m_irdata);
      if (d_valid) d_pulses++;
      if (i_valid) i_pulses++;
      if (m_pend && cyc >= m_resp) m_pend = 1'b0;
      if (!exp_busy && (d_req || i_req)) begin
        m_pend  = 1'b1;
        m_resp  = cyc + LAT + 1;
        m_src_d = d_req;
        m_wr    = d_req && d_wr;
        m_idx   = word_of(d_req ? d_addr : i_addr);
        m_wd    = d_wdata;
      end
    end
  end

  // Waits for the cycle in which the given port's request is accepted.
  task automatic wait_accept(input logic is_d, output int c);
    c = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (is_d ? (d_ready && d_req) : (i_ready && i_req)) begin
        c = cyc;
        return;
      end
    end
    check("accept_timeout", 1'b0, 1'b1);
  endtask

  // Waits for the given port's valid pulse.
  task automatic wait_valid(input logic is_d, output int c);
    c = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (is_d ? d_valid : i_valid) begin
        c = cyc;
        return;
      end
    end
    check("valid_timeout", 1'b0, 1'b1);
  endtask

  // Runs one complete data transaction. It scrambles the request fields after
  // acceptance to show that late changes are ignored.
  task automatic d_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       output int lat, output logic [15:0] rd);
    int ca, cv;
    @(posedge clk); #1;
    d_req = 1'b1; d_wr = wr; d_addr = a; d_wdata = wd;
    wait_accept(1'b1, ca);
    @(posedge clk); #1;
    d_req = 1'b0; d_addr = ~a; d_wdata = ~wd;
    wait_valid(1'b1, cv);
    lat = cv - ca;
    rd  = d_rdata;
  endtask

  initial begin
    int lat, ca, ci, cv, p0;
    int acc[$];
    logic [15:0] rd;

    // Reset held with both requests asserted.
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_d_ready", d_ready, 1'b1);
    check("post_rst_i_ready", i_ready, 1'b0);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) @(posedge clk);

    // Store followed by a load of the same address.
    d_txn(1'b1, 16'h00A4, 16'hBEEF, lat, rd);
    check("store_latency", lat, LAT + 1);
    check("store_rdata", rd, 16'hBEEF);
    p0 = i_pulses;
    d_txn(1'b0, 16'h00A4, 16'h0000, lat, rd);
    check("load_rdata", rd, 16'hBEEF);
    check("load_latency", lat, LAT + 1);
    check("no_i_valid", i_pulses - p0, 0);

    // Simultaneous requests: the data store wins and the fetch stalls.
    @(posedge clk); #1;
    p0 = i_pulses;
    i_req = 1'b1; i_addr = 16'h00A4;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00A4; d_wdata = 16'h1234;
    wait_accept(1'b1, ca);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_accept(1'b0, ci);
    check("i_accept_after_d_resp", ci - ca, LAT + 2);
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = 16'hFFFF;
    wait_valid(1'b0, cv);
    check("prio_i_rdata", i_rdata, 16'h1234);
    repeat (8) @(posedge clk);
    check("prio_i_pulses", i_pulses - p0, 1);

    // Address aliasing via the ignored LSB and upper bits.
    d_txn(1'b1, 16'h0010, 16'h5555, lat, rd);
    d_txn(1'b0, 16'h0011, 16'h0000, lat, rd);
    check("alias_lsb", rd, 16'h5555);
    d_txn(1'b0, 16'h0810, 16'h0000, lat, rd);
    check("alias_wrap", rd, 16'h5555);

    // Reset in the middle of a store drops the store.
    d_txn(1'b1, 16'h0020, 16'h0000, lat, rd);
    @(posedge clk); #1;
    p0 = d_pulses;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'hFFFF;
    wait_accept(1'b1, ca);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("midrst_no_valid", d_pulses - p0, 0);
    d_txn(1'b0, 16'h0020, 16'h0000, lat, rd);
    check("midrst_not_committed", rd, 16'h0000);

    // Back-to-back loads with d_req held high.
    @(posedge clk); #1;
    p0 = d_pulses;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h00A4;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_ready) acc.push_back(cyc);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("b2b_accepts", acc.size(), 4);
    for (int n = 1; n < acc.size(); n++)
      check("b2b_spacing", acc[n] - acc[n-1], LAT + 2);
    check("b2b_valids", d_pulses - p0, acc.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle memory model that serves the pipelined CPU's memory requests: instruction fetches from the fetch stage and loads/stores from the memory stage.
- It sits behind the CPU's instruction and data ports and replaces the single-cycle memories.
- Accepts one request at a time through a req/ready handshake, with data priority over instruction.
- Returns a one-cycle valid pulse a fixed, parameterised number of cycles after acceptance.

Parameters:
- DEPTH_LOG2, 10, log2 of storage depth in 16-bit words; word index = addr[DEPTH_LOG2:1].
- LATENCY, 4, number of BUSY cycles between acceptance and response; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_req  input  1  instruction read request; held stable until accepted.
- i_addr  input  16  instruction byte address; bit 0 ignored.
- i_ready  output  1  instruction request accepted this cycle if i_req is also high.
- i_valid  output  1  one-cycle pulse; i_rdata holds the fetched word.
- i_rdata  output  16  fetched instruction word.
- d_req  input  1  data request; held stable until accepted.
- d_wr  input  1  1 = store, 0 = load.
- d_addr  input  16  data byte address; bit 0 ignored.
- d_wdata  input  16  store data.
- d_ready  output  1  data request accepted this cycle if d_req is also high.
- d_valid  output  1  one-cycle completion pulse for loads and stores.
- d_rdata  output  16  load data; equals the written data on a store completion.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n).
  - While rst_n is low: state = IDLE, counter = 0, i_valid = d_valid = 0, i_rdata = d_rdata = 0x0000, busy = 0.
  - Storage array is not reset; its contents are undefined until written.
- FSM states: IDLE, BUSY, RESP.
- Ready logic:
  - d_ready = (state == IDLE).
  - i_ready = (state == IDLE) & !d_req.
  - Both ready signals are combinational from state and d_req.
- IDLE:
  - If d_req: latch source = D, d_wr, word index and d_wdata; counter <= LATENCY-1; go to BUSY.
  - Else if i_req: latch source = I and word index; counter <= LATENCY-1; go to BUSY.
  - Else stay in IDLE.
- BUSY:
  - If counter != 0: decrement.
  - If counter == 0, at that edge:
    - Perform the access. A store writes mem[idx] <= wdata and updates d_rdata <= wdata. A load updates the selected rdata from mem[idx].
    - Go to RESP.
- RESP:
  - The valid output for the latched source is 1 for exactly this cycle; the other valid stays 0.
  - Next edge: go to IDLE.
- Latency and throughput:
  - Accept edge k -> valid high in the cycle following edge k+LATENCY.
  - Ready is low during BUSY and RESP; peak throughput is one request per LATENCY+2 cycles.
- rdata registers hold their last value until that port's next response.
- Simultaneous i_req and d_req in IDLE: D wins and I stalls. I is accepted on the first IDLE cycle in which d_req is low.
- Requests arriving during BUSY/RESP are not accepted and have no effect. Changes to addr/wdata after acceptance have no effect.
- Address wrap: bits above DEPTH_LOG2 are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- Reset mid-operation: the pending request is dropped with no valid pulse. A store not yet at its BUSY->RESP edge is not committed.
- A store completes before any later-accepted load, so read-after-write returns the new data.

Test Plan:
- Reset: hold rst_n low 3 cycles with i_req = d_req = 1 -> i_valid = d_valid = 0, rdata = 0x0000, busy = 0. After release, d_ready = 1 and i_ready = 0.
- Store then load:
  - Store d_addr = 0x00A4, d_wdata = 0xBEEF, LATENCY = 4 -> d_valid pulses in the 5th cycle after the accept edge, d_rdata = 0xBEEF.
  - Then load 0x00A4 -> d_valid with d_rdata = 0xBEEF; i_valid stays 0 throughout.
- Priority: i_req (i_addr 0x00A4) and d_req (store 0x1234 to 0x00A4) asserted in the same IDLE cycle -> D completes first. I is accepted on the IDLE cycle after D's RESP, returns i_rdata = 0x1234, and pulses i_valid exactly once.
- Alias/LSB:
  - Store 0x5555 to 0x0010 -> load 0x0011 returns 0x5555.
  - Load 0x0810 (DEPTH_LOG2 = 10) returns 0x5555.
- Reset mid-operation:
  - Store 0x0000 to 0x0020 and let it complete.
  - Accept a store of 0xFFFF to 0x0020, then pull rst_n low 2 cycles after acceptance -> no d_valid.
  - After reset, load 0x0020 returns 0x0000.
- Back-to-back: hold d_req high for 20 cycles (loads) -> accepts spaced exactly LATENCY+2 cycles apart. busy is low only on the IDLE accept cycles, and exactly one d_valid per accept.
